// File: rtl/exbus_cycle_ctrl_if.sv
// exbus_cycle_ctrl_if: sequencer command channel plus external async-SRAM bus
// Ports: cmd/cmd_valid/addr/wdata and mem_din/mem_wait are driven by the master side;
// cmd_ready/rdata/done/bus_err/fetch_cycle and mem_addr/mem_dout/strobes are driven by the slave side.
interface exbus_cycle_ctrl_if;
  logic [3:0] cmd;
  logic cmd_valid;
  logic cmd_ready;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic done;
  logic bus_err;
  logic fetch_cycle;
  logic [15:0] mem_addr;
  logic [7:0] mem_dout;
  logic [7:0] mem_din;
  logic mem_cs_n;
  logic mem_oe_n;
  logic mem_we_n;
  logic mem_wait;
  modport master (
    output cmd, cmd_valid, addr, wdata, mem_din, mem_wait,
    input cmd_ready, rdata, done, bus_err, fetch_cycle, mem_addr, mem_dout, mem_cs_n, mem_oe_n, mem_we_n
  );
  modport slave (
    input cmd, cmd_valid, addr, wdata, mem_din, mem_wait,
    output cmd_ready, rdata, done, bus_err, fetch_cycle, mem_addr, mem_dout, mem_cs_n, mem_oe_n, mem_we_n
  );
endinterface

// File: rtl/exbus_cycle_ctrl.sv
// exbus_cycle_ctrl: executes one sequencer bus command as strobed SRAM cycles with wait/timeout
// Ports: clk, reset (sync, active-high), bus (slave modport: command channel and memory bus).
module exbus_cycle_ctrl (
  input logic clk,
  input logic reset,
  exbus_cycle_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_STB1  = 3'd2;
  localparam logic [2:0] S_STB2  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  logic [2:0] state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] cnt_q;
  logic [15:0] buf_q;
  logic [7:0] wlo_q;
  logic beat_q;
  logic start, rd, wr, wide, tmo, busy, strobe;
  assign bus.cmd_ready = state_q == S_IDLE;
  // Strobe/select outputs are registered, so they are decoded from the next state and next opcode.
  always_comb begin
    start = bus.cmd_valid && state_q == S_IDLE && bus.cmd != 4'd0 && bus.cmd <= 4'd5;
    op_d = start ? bus.cmd : op_q;
    rd = op_d == 4'd1 || op_d == 4'd3 || op_d == 4'd4;
    wr = op_d == 4'd2 || op_d == 4'd5;
    wide = op_d == 4'd4 || op_d == 4'd5;
    tmo = state_q == S_STB2 && bus.mem_wait && cnt_q == 4'd15;
    state_d = state_q == S_IDLE ? (start ? S_SETUP : S_IDLE) :
              state_q == S_SETUP ? S_STB1 :
              state_q == S_STB1 ? S_STB2 :
              state_q == S_STB2 ? (!bus.mem_wait ? S_HOLD : tmo ? S_DONE : S_STB2) :
              state_q == S_HOLD ? (wide && !beat_q ? S_SETUP : S_DONE) : S_IDLE;
    busy = state_d >= S_SETUP && state_d <= S_HOLD;
    strobe = state_d == S_STB1 || state_d == S_STB2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= 4'd0;
      cnt_q <= 4'd0;
      buf_q <= 16'd0;
      wlo_q <= 8'd0;
      beat_q <= 1'b0;
      bus.rdata <= 16'd0;
      bus.done <= 1'b0;
      bus.bus_err <= 1'b0;
      bus.fetch_cycle <= 1'b0;
      bus.mem_addr <= 16'd0;
      bus.mem_dout <= 8'd0;
      bus.mem_cs_n <= 1'b1;
      bus.mem_oe_n <= 1'b1;
      bus.mem_we_n <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= state_q == S_STB2 && bus.mem_wait ? cnt_q + 4'd1 : 4'd0;
      if (start) begin
        wlo_q <= bus.wdata[7:0];
        beat_q <= 1'b0;
        bus.mem_addr <= bus.addr;
        bus.mem_dout <= bus.cmd == 4'd5 ? bus.wdata[15:8] : bus.wdata[7:0];
      end
      if (state_q == S_HOLD && state_d == S_SETUP) begin
        beat_q <= 1'b1;
        bus.mem_addr <= bus.mem_addr + 16'd1;
        bus.mem_dout <= wlo_q;
      end
      // Shifting in each beat leaves the first byte in the high half for READ16.
      if (state_q == S_STB2 && !bus.mem_wait) buf_q <= {buf_q[7:0], bus.mem_din};
      if (state_d == S_DONE && rd) bus.rdata <= tmo ? 16'hFFFF : wide ? buf_q : {8'h00, buf_q[7:0]};
      bus.done <= state_d == S_DONE;
      bus.bus_err <= tmo;
      bus.fetch_cycle <= busy && op_d == 4'd3;
      bus.mem_cs_n <= !busy;
      bus.mem_oe_n <= !(rd && strobe);
      bus.mem_we_n <= !(wr && strobe);
    end
  end
endmodule
